// File: rtl/rp_spi_pkg.sv
// Shared definitions for the SPI simulator config bus: register offsets,
// sequencer sizing defaults and sequencer state encoding.
package rp_spi_pkg;

  localparam int SEQ_DEPTH   = 8;
  localparam int SEQ_IDXW    = 3;
  localparam int SEQ_DWELL_W = 16;

  localparam logic [19:0] SIM_FLAG   = 20'h00034;
  localparam logic [19:0] SIM_BITS   = 20'h00038;
  localparam logic [19:0] MOSI0      = 20'h0003C;
  localparam logic [19:0] MOSI1      = 20'h00040;
  localparam logic [19:0] MOSI2      = 20'h00044;
  localparam logic [19:0] MOSI3      = 20'h00048;
  localparam logic [19:0] MOSI4      = 20'h0004C;
  localparam logic [19:0] SIM_PERIOD = 20'h0005C;
  localparam logic [19:0] SEQ_CTRL   = 20'h00060;
  localparam logic [19:0] SEQ_LEN    = 20'h00064;
  localparam logic [19:0] SEQ_WPTR   = 20'h00068;
  localparam logic [19:0] SEQ_EADDR  = 20'h0006C;
  localparam logic [19:0] SEQ_EDATA  = 20'h00070;
  localparam logic [19:0] SEQ_EDWELL = 20'h00074;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_ISSUE = 3'd2,
    ST_DWELL = 3'd3,
    ST_DONE  = 3'd4
  } seq_state_t;

endpackage

// File: rtl/rp_spi_seq_table.sv
// Scenario table: DEPTH entries, one write port, one registered read port.
// Contents are deliberately left unreset; only programmed entries are replayed.
module rp_spi_seq_table #(
  parameter int DEPTH = 8,
  parameter int IDXW  = 3,
  parameter int W     = 80
) (
  input  logic            clk,
  input  logic            wr_en,
  input  logic [IDXW-1:0] wr_idx,
  input  logic [W-1:0]    wr_data,
  input  logic            rd_en,
  input  logic [IDXW-1:0] rd_idx,
  output logic [W-1:0]    rd_data
);

  logic [W-1:0] mem_q [DEPTH];
  logic [W-1:0] rd_data_q;

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_idx] <= wr_data;
    if (rd_en) rd_data_q <= mem_q[rd_idx];
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/rp_spi_sim_seq.sv
// Replays a CPU-programmed table of (addr, data, dwell) writes into the SPI
// simulator config port; CPU writes always pass through first.
module rp_spi_sim_seq
  import rp_spi_pkg::*;
#(
  parameter int DEPTH   = SEQ_DEPTH,
  parameter int IDXW    = SEQ_IDXW,
  parameter int DWELL_W = SEQ_DWELL_W
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic [31:0]     sys_addr,
  input  logic [31:0]     sys_wdata,
  input  logic            sys_wen,
  input  logic            sim_cs,
  output logic [31:0]     sim_addr,
  output logic [31:0]     sim_wdata,
  output logic            sim_wen,
  output logic            seq_busy,
  output logic            seq_done,
  output logic [IDXW-1:0] seq_idx
);

  localparam int EW = 64 + DWELL_W;

  seq_state_t        state_q, state_d;
  logic [1:0]        ctrl_q, ctrl_d;
  logic [IDXW:0]     len_q, len_d;
  logic [IDXW-1:0]   wptr_q, wptr_d;
  logic [31:0]       eaddr_q, eaddr_d;
  logic [31:0]       edata_q, edata_d;
  logic [IDXW-1:0]   idx_q, idx_d;
  logic [DWELL_W-1:0] cnt_q, cnt_d;
  logic              cs_d_q, cs_d_d;
  logic [31:0]       sim_addr_q, sim_addr_d;
  logic [31:0]       sim_wdata_q, sim_wdata_d;
  logic              sim_wen_q, sim_wen_d;
  logic [IDXW-1:0]   seq_idx_q, seq_idx_d;

  logic              tbl_wr, tbl_rd;
  logic [EW-1:0]     tbl_rdata;
  logic [19:0]       reg_off;
  logic              msg_end, disable_now;
  logic [IDXW:0]     idx_nxt;
  logic [DWELL_W-1:0] cnt_dec;

  rp_spi_seq_table #(.DEPTH(DEPTH), .IDXW(IDXW), .W(EW)) u_table (
    .clk     (clk),
    .wr_en   (tbl_wr),
    .wr_idx  (wptr_q),
    .wr_data ({eaddr_q, edata_q, sys_wdata[DWELL_W-1:0]}),
    .rd_en   (tbl_rd),
    .rd_idx  (idx_q),
    .rd_data (tbl_rdata)
  );

  assign reg_off     = sys_addr[19:0];
  assign msg_end     = sim_cs & ~cs_d_q;
  // A ctrl write clearing enable takes effect immediately, not a cycle late.
  assign disable_now = ~ctrl_q[0] | (sys_wen & (reg_off == SEQ_CTRL) & ~sys_wdata[0]);
  assign idx_nxt     = {1'b0, idx_q} + {{IDXW{1'b0}}, 1'b1};
  assign cnt_dec     = (msg_end && cnt_q != '0) ? cnt_q - 1'b1 : cnt_q;

  always_comb begin
    state_d     = state_q;
    ctrl_d      = ctrl_q;
    len_d       = len_q;
    wptr_d      = wptr_q;
    eaddr_d     = eaddr_q;
    edata_d     = edata_q;
    idx_d       = idx_q;
    cnt_d       = cnt_q;
    cs_d_d      = sim_cs;
    sim_addr_d  = sim_addr_q;
    sim_wdata_d = sim_wdata_q;
    sim_wen_d   = 1'b0;
    seq_idx_d   = seq_idx_q;
    tbl_wr      = 1'b0;
    tbl_rd      = 1'b0;

    if (sys_wen) begin
      sim_addr_d  = sys_addr;
      sim_wdata_d = sys_wdata;
      sim_wen_d   = 1'b1;
      case (reg_off)
        SEQ_CTRL:   ctrl_d = sys_wdata[1:0];
        SEQ_LEN:    len_d = (sys_wdata > 32'(DEPTH)) ? (IDXW+1)'(DEPTH) : sys_wdata[IDXW:0];
        SEQ_WPTR:   wptr_d = sys_wdata[IDXW-1:0];
        SEQ_EADDR:  eaddr_d = sys_wdata;
        SEQ_EDATA:  edata_d = sys_wdata;
        SEQ_EDWELL: begin
          tbl_wr = 1'b1;
          wptr_d = (wptr_q == IDXW'(DEPTH-1)) ? '0 : wptr_q + 1'b1;
        end
        default: ;
      endcase
    end

    case (state_q)
      ST_IDLE: begin
        if (ctrl_q[0] && len_q != '0) begin
          idx_d   = '0;
          state_d = ST_LOAD;
        end
      end
      ST_LOAD: begin
        tbl_rd  = 1'b1;
        state_d = ST_ISSUE;
      end
      ST_ISSUE: begin
        // Only free cycles are used; a blocked issue simply retries.
        if (!sys_wen && !disable_now) begin
          sim_addr_d  = tbl_rdata[EW-1 -: 32];
          sim_wdata_d = tbl_rdata[DWELL_W +: 32];
          sim_wen_d   = 1'b1;
          seq_idx_d   = idx_q;
          cnt_d       = tbl_rdata[DWELL_W-1:0];
          state_d     = ST_DWELL;
        end
      end
      ST_DWELL: begin
        cnt_d = cnt_dec;
        if (cnt_dec == '0) begin
          if (idx_nxt < len_q) begin
            idx_d   = idx_nxt[IDXW-1:0];
            state_d = ST_LOAD;
          end else if (ctrl_q[1]) begin
            idx_d   = '0;
            state_d = ST_LOAD;
          end else begin
            state_d = ST_DONE;
          end
        end
      end
      ST_DONE: ;
      default: state_d = ST_IDLE;
    endcase

    if (disable_now) state_d = ST_IDLE;
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q     <= ST_IDLE;
      ctrl_q      <= '0;
      len_q       <= '0;
      wptr_q      <= '0;
      eaddr_q     <= '0;
      edata_q     <= '0;
      idx_q       <= '0;
      cnt_q       <= '0;
      cs_d_q      <= 1'b1;
      sim_addr_q  <= '0;
      sim_wdata_q <= '0;
      sim_wen_q   <= 1'b0;
      seq_idx_q   <= '0;
    end else begin
      state_q     <= state_d;
      ctrl_q      <= ctrl_d;
      len_q       <= len_d;
      wptr_q      <= wptr_d;
      eaddr_q     <= eaddr_d;
      edata_q     <= edata_d;
      idx_q       <= idx_d;
      cnt_q       <= cnt_d;
      cs_d_q      <= cs_d_d;
      sim_addr_q  <= sim_addr_d;
      sim_wdata_q <= sim_wdata_d;
      sim_wen_q   <= sim_wen_d;
      seq_idx_q   <= seq_idx_d;
    end
  end

  assign sim_addr  = sim_addr_q;
  assign sim_wdata = sim_wdata_q;
  assign sim_wen   = sim_wen_q;
  assign seq_idx   = seq_idx_q;
  assign seq_done  = (state_q == ST_DONE);
  assign seq_busy  = (state_q == ST_LOAD) || (state_q == ST_ISSUE) || (state_q == ST_DWELL);

endmodule
